timer_sequencer: RTL and testbench

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_sequencer_if.sv | 22 ++
 rtl/timer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_timer_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_sequencer_if.sv
// Timer register bus between the sequencer (master) and the timer block (slave).
// Latency: none, wires only. Backpressure: the slave stalls a write by holding t_rdy_ high.
// Signals: active-low strobes t_cs_/t_as_, t_rw (1 = read), t_addr, t_wr_data, t_rdy_, irq_in.
interface timer_sequencer_if;
   logic        t_cs_;
   logic        t_as_;
   logic        t_rw;
   logic [1:0]  t_addr;
   logic [31:0] t_wr_data;
   logic        t_rdy_;
   logic        irq_in;

   modport master (
      output t_cs_, t_as_, t_rw, t_addr, t_wr_data,
      input  t_rdy_, irq_in
   );

   modport slave (
      input  t_cs_, t_as_, t_rw, t_addr, t_wr_data,
      output t_rdy_, irq_in
   );
endinterface

// File: rtl/timer_sequencer.sv
// Programs a timer over its register bus, services its interrupts and runs stop sequences.
// Latency: first strobe the cycle after an accepted cmd_start; tick/done are registered, one cycle after the deciding edge.
// Backpressure: each write holds its state until t_rdy_ is seen low; commands that cannot be taken are dropped or deferred.
// Ports: clk, reset (sync, active-high); cmd_start/cmd_stop pulses; cfg_period/cfg_periodic
//        captured at start; busy/tick/done/event_cnt status; bus = timer register bus (master side).
module timer_sequencer (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_start,
   input  logic               cmd_stop,
   input  logic [31:0]        cfg_period,
   input  logic               cfg_periodic,
   output logic               busy,
   output logic               tick,
   output logic               done,
   output logic [15:0]        event_cnt,
   timer_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE, W_EXPR, W_CNT, W_CTRL, RUN, CLR_IRQ, STOP_CTRL, STOP_CLR
   } state_t;

   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_INTR = 2'd1;
   localparam logic [1:0] A_EXPR = 2'd2;
   localparam logic [1:0] A_CNT  = 2'd3;

   state_t      state, state_nxt;
   logic        issued, issued_nxt;        // strobe already sent for the current write
   logic        stop_pend, stop_pend_nxt;
   logic        periodic_q, periodic_nxt;
   logic [31:0] period_q, period_nxt;
   logic [15:0] cnt_q, cnt_nxt;
   logic        tick_q, tick_nxt;
   logic        done_q, done_nxt;

   logic wr_state;   // every state other than IDLE and RUN performs exactly one write
   logic issue;      // the single strobe cycle of that write
   logic wr_done;    // ready seen during the wait phase
   logic stop_seen;  // a stop arriving on the completing cycle still redirects

   assign wr_state  = (state != IDLE) && (state != RUN);
   assign issue     = wr_state && !issued;
   assign wr_done   = wr_state && issued && !bus.t_rdy_;
   assign stop_seen = stop_pend || cmd_stop;

   assign busy      = (state != IDLE);
   assign tick      = tick_q;
   assign done      = done_q;
   assign event_cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         issued     <= 1'b0;
         stop_pend  <= 1'b0;
         periodic_q <= 1'b0;
         period_q   <= '0;
         cnt_q      <= '0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         issued     <= issued_nxt;
         stop_pend  <= stop_pend_nxt;
         periodic_q <= periodic_nxt;
         period_q   <= period_nxt;
         cnt_q      <= cnt_nxt;
         tick_q     <= tick_nxt;
         done_q     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      stop_pend_nxt = stop_pend;
      period_nxt    = period_q;
      periodic_nxt  = periodic_q;
      cnt_nxt       = cnt_q;
      tick_nxt      = 1'b0;
      done_nxt      = 1'b0;
      // cleared on completion so the next write state starts with a fresh strobe
      issued_nxt    = wr_state && !wr_done;

      if (wr_state && cmd_stop)
         stop_pend_nxt = 1'b1;

      case (state)
         IDLE: begin
            if (cmd_start && !cmd_stop) begin
               period_nxt   = cfg_period;
               periodic_nxt = cfg_periodic;
               cnt_nxt      = '0;
               state_nxt    = W_EXPR;
            end
         end
         W_EXPR: if (wr_done) state_nxt = stop_seen ? STOP_CTRL : W_CNT;
         W_CNT:  if (wr_done) state_nxt = stop_seen ? STOP_CTRL : W_CTRL;
         W_CTRL: if (wr_done) state_nxt = stop_seen ? STOP_CTRL : RUN;
         RUN: begin
            // an expiry wins over a simultaneous stop; the stop is replayed after the clear
            if (bus.irq_in) begin
               tick_nxt  = 1'b1;
               cnt_nxt   = cnt_q + 16'd1;
               state_nxt = CLR_IRQ;
               if (cmd_stop)
                  stop_pend_nxt = 1'b1;
            end else if (cmd_stop) begin
               state_nxt = STOP_CTRL;
            end
         end
         CLR_IRQ: begin
            if (wr_done) begin
               if (stop_seen) begin
                  state_nxt = STOP_CTRL;
               end else if (!periodic_q) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = RUN;
               end
            end
         end
         STOP_CTRL: if (wr_done) state_nxt = STOP_CLR;
         STOP_CLR: begin
            if (wr_done) begin
               done_nxt      = 1'b1;
               stop_pend_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus is idle-valued everywhere except the one strobe cycle of each write.
   always_comb begin
      bus.t_cs_     = !issue;
      bus.t_as_     = !issue;
      bus.t_rw      = !issue;
      bus.t_addr    = A_CTRL;
      bus.t_wr_data = '0;
      if (issue) begin
         case (state)
            W_EXPR: begin
               bus.t_addr    = A_EXPR;
               bus.t_wr_data = period_q;
            end
            W_CNT:     bus.t_addr = A_CNT;
            W_CTRL: begin
               bus.t_addr    = A_CTRL;
               bus.t_wr_data = {30'd0, periodic_q, 1'b1};
            end
            CLR_IRQ:   bus.t_addr = A_INTR;
            STOP_CTRL: bus.t_addr = A_CTRL;
            STOP_CLR:  bus.t_addr = A_INTR;
            default:   bus.t_addr = A_CTRL;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: a behavioural timer answers bus writes and raises irq_in,
// a table of scenarios is run and the logged writes, ticks and done pulses compared,
// then hand-written sequences cover ignored commands and reset during a write.
module tb_timer_sequencer;

   logic        clk;
   logic        reset;
   logic        cmd_start;
   logic        cmd_stop;
   logic [31:0] cfg_period;
   logic        cfg_periodic;
   logic        busy;
   logic        tick;
   logic        done;
   logic [15:0] event_cnt;

   timer_sequencer_if bus ();

   timer_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_start    (cmd_start),
      .cmd_stop     (cmd_stop),
      .cfg_period   (cfg_period),
      .cfg_periodic (cfg_periodic),
      .busy         (busy),
      .tick         (tick),
      .done         (done),
      .event_cnt    (event_cnt),
      .bus          (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- timer model and monitor (sole writer of the logs) ----------------
   int          rdy_delay = 1;
   int          wait_cnt  = 0;
   int          cyc       = 0;
   logic        tmr_run   = 1'b0;
   logic        tmr_per   = 1'b0;
   logic [31:0] tmr_expr  = '0;
   logic [31:0] tmr_ctr   = '0;

   logic [34:0] wr_q[$];        // {rw, addr, data} per strobe cycle
   int          tick_cyc_q[$];
   logic [15:0] tick_cnt_q[$];
   logic        done_busy_q[$]; // busy value seen with each done pulse

   initial begin
      bus.t_rdy_ = 1'b1;
      bus.irq_in = 1'b0;
      forever begin
         @(negedge clk);
         bus.t_rdy_ = 1'b1;
         if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) bus.t_rdy_ = 1'b0;
         end
         if (tmr_run && !bus.irq_in) begin
            tmr_ctr = tmr_ctr + 32'd1;
            if (tmr_ctr == tmr_expr + 32'd1) begin
               bus.irq_in = 1'b1;
               tmr_ctr    = '0;
               if (!tmr_per) tmr_run = 1'b0;
            end
         end
         if (reset) begin
            tmr_run    = 1'b0;
            bus.irq_in = 1'b0;
         end
         if (!bus.t_cs_ && !bus.t_as_) begin
            wr_q.push_back({bus.t_rw, bus.t_addr, bus.t_wr_data});
            wait_cnt = rdy_delay;
            case (bus.t_addr)
               2'd0: begin
                  tmr_run = bus.t_wr_data[0];
                  tmr_per = bus.t_wr_data[1];
               end
               2'd1: bus.irq_in = bus.t_wr_data[0];
               2'd2: tmr_expr = bus.t_wr_data;
               default: tmr_ctr = bus.t_wr_data;
            endcase
         end
         if (tick) begin
            tick_cyc_q.push_back(cyc);
            tick_cnt_q.push_back(event_cnt);
         end
         if (done) done_busy_q.push_back(busy);
         cyc++;
      end
   end

   // ---------------- scenario table ----------------
   // mode 0: run to completion; 1: stop in RUN; 2: stop during W_CNT;
   // 3: stop on the same cycle as irq; 4: stop right after the third tick
   typedef struct {
      logic [31:0]      period;
      logic             periodic;
      int               mode;
      int               rdy;
      logic             dbl_start;
      int               n_wr;
      logic [7:0][34:0] exp_wr;
      int               n_tick;
      logic [15:0]      exp_cnt;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [34:0] w(input logic [1:0] a, input logic [31:0] d);
      return {1'b0, a, d};
   endfunction

   function automatic bit trig(input int mode, input int wb, input int tb);
      case (mode)
         1:       return (wr_q.size() - wb) >= 3;
         2:       return (wr_q.size() - wb) >= 2;
         3:       return bus.irq_in == 1'b1;
         default: return (tick_cyc_q.size() - tb) >= 3;
      endcase
   endfunction

   task automatic fill_vecs();
      for (int i = 0; i < 6; i++) begin
         vecs[i].exp_wr    = '0;
         vecs[i].dbl_start = 1'b0;
      end
      // one-shot, prompt ready
      vecs[0].period = 32'd4;  vecs[0].periodic = 1'b0; vecs[0].mode = 0; vecs[0].rdy = 1;
      vecs[0].n_wr = 4; vecs[0].n_tick = 1; vecs[0].exp_cnt = 16'd1;
      vecs[0].exp_wr[0] = w(2, 4); vecs[0].exp_wr[1] = w(3, 0);
      vecs[0].exp_wr[2] = w(0, 1); vecs[0].exp_wr[3] = w(1, 0);
      // one-shot, ready three cycles after strobe
      vecs[1] = vecs[0];
      vecs[1].rdy = 3;
      // periodic, three ticks then stop
      vecs[2].period = 32'd9;  vecs[2].periodic = 1'b1; vecs[2].mode = 4; vecs[2].rdy = 1;
      vecs[2].n_wr = 8; vecs[2].n_tick = 3; vecs[2].exp_cnt = 16'd3;
      vecs[2].exp_wr[0] = w(2, 9); vecs[2].exp_wr[1] = w(3, 0); vecs[2].exp_wr[2] = w(0, 3);
      vecs[2].exp_wr[3] = w(1, 0); vecs[2].exp_wr[4] = w(1, 0); vecs[2].exp_wr[5] = w(1, 0);
      vecs[2].exp_wr[6] = w(0, 0); vecs[2].exp_wr[7] = w(1, 0);
      // stop in RUN, with a second start while busy that must be ignored
      vecs[3].period = 32'd1000; vecs[3].periodic = 1'b1; vecs[3].mode = 1; vecs[3].rdy = 1;
      vecs[3].dbl_start = 1'b1;
      vecs[3].n_wr = 5; vecs[3].n_tick = 0; vecs[3].exp_cnt = 16'd0;
      vecs[3].exp_wr[0] = w(2, 1000); vecs[3].exp_wr[1] = w(3, 0); vecs[3].exp_wr[2] = w(0, 3);
      vecs[3].exp_wr[3] = w(0, 0);    vecs[3].exp_wr[4] = w(1, 0);
      // stop while COUNTER write is in flight
      vecs[4].period = 32'd20; vecs[4].periodic = 1'b1; vecs[4].mode = 2; vecs[4].rdy = 3;
      vecs[4].n_wr = 4; vecs[4].n_tick = 0; vecs[4].exp_cnt = 16'd0;
      vecs[4].exp_wr[0] = w(2, 20); vecs[4].exp_wr[1] = w(3, 0);
      vecs[4].exp_wr[2] = w(0, 0);  vecs[4].exp_wr[3] = w(1, 0);
      // irq and stop on the same RUN cycle
      vecs[5].period = 32'd5;  vecs[5].periodic = 1'b1; vecs[5].mode = 3; vecs[5].rdy = 2;
      vecs[5].n_wr = 6; vecs[5].n_tick = 1; vecs[5].exp_cnt = 16'd1;
      vecs[5].exp_wr[0] = w(2, 5); vecs[5].exp_wr[1] = w(3, 0); vecs[5].exp_wr[2] = w(0, 3);
      vecs[5].exp_wr[3] = w(1, 0); vecs[5].exp_wr[4] = w(0, 0); vecs[5].exp_wr[5] = w(1, 0);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int   wb, tb, db, k, nw, nt;
      v  = vecs[i];
      rdy_delay = v.rdy;
      wb = wr_q.size();
      tb = tick_cyc_q.size();
      db = done_busy_q.size();

      @(negedge clk); #1;
      cfg_period   = v.period;
      cfg_periodic = v.periodic;
      cmd_start    = 1'b1;
      @(negedge clk); #1;
      cmd_start    = 1'b0;

      if (v.dbl_start) begin
         cfg_period   = 32'd7;
         cfg_periodic = 1'b0;
         cmd_start    = 1'b1;
         @(negedge clk); #1;
         cmd_start    = 1'b0;
      end

      if (v.mode != 0) begin
         k = 0;
         while (!trig(v.mode, wb, tb) && k < 400) begin
            @(negedge clk); #1;
            k++;
         end
         if (k >= 400) begin
            check($sformatf("v%0d stop trigger timeout", i), 64'd1, 64'd0);
         end else begin
            if (v.mode == 1) begin
               repeat (3) @(negedge clk);
               #1;
            end
            cmd_stop = 1'b1;
            @(negedge clk); #1;
            cmd_stop = 1'b0;
         end
      end

      k = 0;
      while (done_busy_q.size() == db && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
      repeat (6) @(negedge clk);
      #1;

      nw = wr_q.size() - wb;
      nt = tick_cyc_q.size() - tb;
      check($sformatf("v%0d write count", i), 64'(nw), 64'(v.n_wr));
      for (int j = 0; j < v.n_wr && j < nw; j++)
         check($sformatf("v%0d write%0d {rw,addr,data}", i, j), 64'(wr_q[wb + j]), 64'(v.exp_wr[j]));
      check($sformatf("v%0d tick count", i), 64'(nt), 64'(v.n_tick));
      for (int j = 0; j < nt; j++)
         check($sformatf("v%0d event_cnt at tick%0d", i, j), 64'(tick_cnt_q[tb + j]), 64'(j + 1));
      check($sformatf("v%0d done pulses", i), 64'(done_busy_q.size() - db), 64'd1);
      if (done_busy_q.size() > db)
         check($sformatf("v%0d busy with done", i), 64'(done_busy_q[db]), 64'd0);
      check($sformatf("v%0d final event_cnt", i), 64'(event_cnt), 64'(v.exp_cnt));
      check($sformatf("v%0d final busy", i), 64'(busy), 64'd0);
      // timer expires after period+1 counted cycles; one more to sample and register the tick
      if (v.mode == 4 && nt >= 3) begin
         check($sformatf("v%0d tick interval 1-2", i),
               64'(tick_cyc_q[tb + 1] - tick_cyc_q[tb]), 64'(v.period + 2));
         check($sformatf("v%0d tick interval 2-3", i),
               64'(tick_cyc_q[tb + 2] - tick_cyc_q[tb + 1]), 64'(v.period + 2));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " busy"},      64'(busy),          64'd0);
      check({tag, " tick"},      64'(tick),          64'd0);
      check({tag, " done"},      64'(done),          64'd0);
      check({tag, " event_cnt"}, 64'(event_cnt),     64'd0);
      check({tag, " bus strobes/rw"}, 64'({bus.t_cs_, bus.t_as_, bus.t_rw}), 64'b111);
      check({tag, " t_addr"},    64'(bus.t_addr),    64'd0);
      check({tag, " t_wr_data"}, 64'(bus.t_wr_data), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int wb, db;
      reset        = 1'b1;
      cmd_start    = 1'b0;
      cmd_stop     = 1'b0;
      cfg_period   = '0;
      cfg_periodic = 1'b0;
      fill_vecs();

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      #1 reset = 1'b0;

      // stop alone in IDLE, then start together with stop: both dropped
      wb = wr_q.size();
      db = done_busy_q.size();
      @(negedge clk); #1 cmd_stop = 1'b1;
      @(negedge clk); #1 cmd_stop = 1'b0;
      cfg_period = 32'd3;
      cmd_start  = 1'b1;
      cmd_stop   = 1'b1;
      @(negedge clk); #1;
      cmd_start  = 1'b0;
      cmd_stop   = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("idle cmds busy",    64'(busy), 64'd0);
      check("idle cmds writes",  64'(wr_q.size() - wb), 64'd0);
      check("idle cmds done",    64'(done_busy_q.size() - db), 64'd0);

      for (int i = 0; i < 6; i++)
         run_vec(i);

      // reset while waiting on a slow ready: write abandoned, no further strobe
      rdy_delay = 3;
      wb = wr_q.size();
      @(negedge clk); #1;
      cfg_period   = 32'd50;
      cfg_periodic = 1'b1;
      cmd_start    = 1'b1;
      @(negedge clk); #1;
      cmd_start    = 1'b0;
      @(negedge clk); #1;
      check("mid-write busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset mid-write");
      #1 reset = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      check("reset mid-write strobes", 64'(wr_q.size() - wb), 64'd1);
      check("reset mid-write idle",    64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global timeout: simulation did not finish, wanted finish before 400000");
      $fatal(1);
   end

endmodule
